// File: rtl/phone_pkg.sv
// Shared types and status words for the phone exchange and its handsets.
// Status words are 8 ASCII characters, first character in the MSB, space padded.
package phone_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DIAL,
    WAIT_RING,
    RINGING,
    CONNECTED,
    HANGUP,
    WAIT_IDLE
  } state_e;

  localparam logic [63:0] STATUS_IDLE     = "IDLE    ";
  localparam logic [63:0] STATUS_RINGING  = "RINGING ";
  localparam logic [63:0] STATUS_CALL     = "CALL    ";
  localparam logic [63:0] STATUS_REJECTED = "REJECTED";
  localparam logic [63:0] STATUS_BUSY     = "BUSY    ";

endpackage

// File: rtl/char_fifo.sv
// Byte-wide synchronous FIFO with first-word fall-through read data.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module char_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_push,
  input  logic       i_pop,
  input  logic [7:0] i_din,
  output logic [7:0] o_dout,
  output logic       o_full,
  output logic       o_empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign o_dout    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/caller_handset.sv
// Caller-side handset: places calls through the exchange, streams typed characters
// while connected, and hangs up on user request or ring timeout.
module caller_handset
  import phone_pkg::*;
#(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned RING_TIMEOUT = 15,
  parameter int unsigned IDLE_TIMEOUT = 7
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_dial,
  input  logic        i_hangup,
  input  logic        i_key_valid,
  input  logic [7:0]  i_key_char,
  input  logic [63:0] i_statusMsg,
  output logic        o_startCall,
  output logic        o_endCallCaller,
  output logic        o_sendCharCaller,
  output logic [7:0]  o_charSent,
  output logic        o_connected,
  output logic        o_ringing,
  output logic        o_fifo_full,
  output logic        o_fifo_empty,
  output logic        o_overflow,
  output logic        o_timed_out,
  output logic [15:0] o_sent_count
);

  state_e      r_state;
  state_e      w_state_d;
  logic [7:0]  r_timer;
  logic        r_start;
  logic        r_end;
  logic        r_send;
  logic [7:0]  r_char;
  logic        r_connected;
  logic        r_ringing;
  logic        r_overflow;
  logic        r_timed_out;
  logic [15:0] r_sent_count;

  logic        w_pop;
  logic        w_ring_to;
  logic        w_dial_ok;
  logic        w_drop;
  logic        w_timed;
  logic        w_ring_exp;
  logic        w_idle_exp;
  logic        w_fifo_full;
  logic        w_fifo_empty;
  logic [7:0]  w_fifo_dout;

  char_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_push (i_key_valid),
    .i_pop  (w_pop),
    .i_din  (i_key_char),
    .o_dout (w_fifo_dout),
    .o_full (w_fifo_full),
    .o_empty(w_fifo_empty)
  );

  assign w_ring_exp = (r_timer >= 8'(RING_TIMEOUT));
  assign w_idle_exp = (r_timer >= 8'(IDLE_TIMEOUT));
  assign w_dial_ok  = (r_state == IDLE) && i_dial;
  assign w_drop     = i_key_valid && w_fifo_full && !w_pop;
  assign w_timed    = (r_state == WAIT_RING) || (r_state == RINGING) || (r_state == WAIT_IDLE);

  // User hangup outranks any exchange status seen in the same cycle.
  always_comb begin
    w_state_d = r_state;
    w_pop     = 1'b0;
    w_ring_to = 1'b0;
    case (r_state)
      IDLE:      if (i_dial) w_state_d = DIAL;
      DIAL:      w_state_d = WAIT_RING;
      WAIT_RING: begin
        if (i_hangup) w_state_d = HANGUP;
        else if (i_statusMsg == STATUS_RINGING) w_state_d = RINGING;
        else if (i_statusMsg == STATUS_BUSY || i_statusMsg == STATUS_REJECTED) w_state_d = IDLE;
        else if (w_ring_exp) begin
          w_state_d = HANGUP;
          w_ring_to = 1'b1;
        end
      end
      RINGING: begin
        if (i_hangup) w_state_d = HANGUP;
        else if (i_statusMsg == STATUS_CALL) w_state_d = CONNECTED;
        else if (i_statusMsg == STATUS_REJECTED || i_statusMsg == STATUS_IDLE) w_state_d = IDLE;
        else if (w_ring_exp) begin
          w_state_d = HANGUP;
          w_ring_to = 1'b1;
        end
      end
      CONNECTED: begin
        // Characters only leave while the call stays up; anything pending survives a hangup.
        if (i_hangup) w_state_d = HANGUP;
        else if (i_statusMsg == STATUS_IDLE) w_state_d = IDLE;
        else w_pop = !w_fifo_empty;
      end
      HANGUP:    w_state_d = WAIT_IDLE;
      WAIT_IDLE: if (i_statusMsg == STATUS_IDLE || w_idle_exp) w_state_d = IDLE;
      default:   w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state      <= IDLE;
      r_timer      <= '0;
      r_start      <= 1'b0;
      r_end        <= 1'b0;
      r_send       <= 1'b0;
      r_char       <= '0;
      r_connected  <= 1'b0;
      r_ringing    <= 1'b0;
      r_overflow   <= 1'b0;
      r_timed_out  <= 1'b0;
      r_sent_count <= '0;
    end else begin
      r_state     <= w_state_d;
      r_start     <= (w_state_d == DIAL);
      r_end       <= (w_state_d == HANGUP);
      r_send      <= w_pop;
      r_char      <= w_pop ? w_fifo_dout : 8'h00;
      r_connected <= (w_state_d == CONNECTED);
      r_ringing   <= (w_state_d == WAIT_RING) || (w_state_d == RINGING);

      if (w_state_d != r_state) r_timer <= '0;
      else if (w_timed && r_timer != 8'hFF) r_timer <= r_timer + 1'b1;

      if (w_drop) r_overflow <= 1'b1;
      else if (w_dial_ok) r_overflow <= 1'b0;

      if (w_ring_to) r_timed_out <= 1'b1;
      else if (w_dial_ok) r_timed_out <= 1'b0;

      if (w_dial_ok) r_sent_count <= '0;
      else if (w_pop && r_sent_count != 16'hFFFF) r_sent_count <= r_sent_count + 1'b1;
    end
  end

  assign o_startCall      = r_start;
  assign o_endCallCaller  = r_end;
  assign o_sendCharCaller = r_send;
  assign o_charSent       = r_char;
  assign o_connected      = r_connected;
  assign o_ringing        = r_ringing;
  assign o_fifo_full      = w_fifo_full;
  assign o_fifo_empty     = w_fifo_empty;
  assign o_overflow       = r_overflow;
  assign o_timed_out      = r_timed_out;
  assign o_sent_count     = r_sent_count;

endmodule

// File: tb/tb_caller_handset.sv
// Scenario bench for caller_handset; typed characters go through a scoreboard queue
// that is checked in order whenever the handset delivers a character.
module tb_caller_handset;

  localparam int unsigned DEPTH        = 8;
  localparam int unsigned RING_TIMEOUT = 15;
  localparam int unsigned IDLE_TIMEOUT = 7;

  localparam logic [63:0] S_IDLE     = 64'h49444C4520202020;
  localparam logic [63:0] S_RINGING  = 64'h52494E47494E4720;
  localparam logic [63:0] S_CALL     = 64'h43414C4C20202020;
  localparam logic [63:0] S_REJECTED = 64'h52454A4543544544;

  // start,end,send,char,connected,ringing,full,empty,overflow,timed_out,sent_count
  localparam logic [32:0] RESET_OUTS = {3'b000, 8'h00, 4'b0001, 2'b00, 16'h0000};

  logic        clk;
  logic        rst_n;
  logic        dial;
  logic        hangup;
  logic        key_valid;
  logic [7:0]  key_char;
  logic [63:0] status;
  logic        startCall;
  logic        endCallCaller;
  logic        sendCharCaller;
  logic [7:0]  charSent;
  logic        connected;
  logic        ringing;
  logic        fifo_full;
  logic        fifo_empty;
  logic        overflow;
  logic        timed_out;
  logic [15:0] sent_count;
  logic [32:0] outs;

  int n_vec;
  int n_err;
  logic [7:0] exp_q[$];

  caller_handset #(
    .DEPTH       (DEPTH),
    .RING_TIMEOUT(RING_TIMEOUT),
    .IDLE_TIMEOUT(IDLE_TIMEOUT)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst_n),
    .i_dial          (dial),
    .i_hangup        (hangup),
    .i_key_valid     (key_valid),
    .i_key_char      (key_char),
    .i_statusMsg     (status),
    .o_startCall     (startCall),
    .o_endCallCaller (endCallCaller),
    .o_sendCharCaller(sendCharCaller),
    .o_charSent      (charSent),
    .o_connected     (connected),
    .o_ringing       (ringing),
    .o_fifo_full     (fifo_full),
    .o_fifo_empty    (fifo_empty),
    .o_overflow      (overflow),
    .o_timed_out     (timed_out),
    .o_sent_count    (sent_count)
  );

  assign outs = {startCall, endCallCaller, sendCharCaller, charSent, connected, ringing,
                 fifo_full, fifo_empty, overflow, timed_out, sent_count};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_key(input logic [7:0] c);
    key_valid = 1'b1;
    key_char  = c;
    tick();
    key_valid = 1'b0;
    if (exp_q.size() < DEPTH) exp_q.push_back(c);
  endtask

  task automatic dial_to_connect();
    dial = 1'b1;
    tick();
    dial   = 1'b0;
    status = S_RINGING;
    tick();
    tick();
    status = S_CALL;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; dial = 1'b0; hangup = 1'b0; key_valid = 1'b0; key_char = 8'h00;
    status = S_IDLE;
    tick();
    tick();
    n_vec++;
    if (outs !== RESET_OUTS) begin
      n_err++;
      $display("FAIL reset_outputs: got %h want %h", outs, RESET_OUTS);
    end
    rst_n = 1'b1;
    tick();
    n_vec++;
    if (outs !== RESET_OUTS) begin
      n_err++;
      $display("FAIL idle_after_release: got %h want %h", outs, RESET_OUTS);
    end
  endtask

  task automatic test_happy_path();
    logic [7:0] exp_c;
    push_key(8'h48);
    push_key(8'h49);
    n_vec++;
    if (fifo_empty !== 1'b0) begin
      n_err++;
      $display("FAIL happy_fifo_loaded: got empty=%b want 0", fifo_empty);
    end
    dial = 1'b1;
    tick();
    dial = 1'b0;
    n_vec++;
    if (startCall !== 1'b1) begin
      n_err++;
      $display("FAIL happy_start_pulse: got %b want 1", startCall);
    end
    tick();
    n_vec++;
    if ({startCall, ringing} !== 2'b01) begin
      n_err++;
      $display("FAIL happy_start_width: got start,ring=%b want 01", {startCall, ringing});
    end
    status = S_RINGING;
    tick();
    status = S_CALL;
    tick();
    n_vec++;
    if (connected !== 1'b1) begin
      n_err++;
      $display("FAIL happy_connected: got %b want 1", connected);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      exp_c = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
      n_vec++;
      if ({sendCharCaller, charSent} !== {1'b1, exp_c}) begin
        n_err++;
        $display("FAIL happy_send%0d: got send,char=%b,%h want 1,%h", i, sendCharCaller,
                 charSent, exp_c);
      end
    end
    tick();
    n_vec++;
    if ({sendCharCaller, sent_count} !== {1'b0, 16'd2}) begin
      n_err++;
      $display("FAIL happy_sent_count: got send,count=%b,%0d want 0,2", sendCharCaller,
               sent_count);
    end
    status = S_IDLE;
    tick();
    n_vec++;
    if ({connected, endCallCaller} !== 2'b00) begin
      n_err++;
      $display("FAIL happy_remote_end: got conn,end=%b want 00", {connected, endCallCaller});
    end
  endtask

  task automatic test_ring_timeout();
    int n;
    bit seen;
    dial = 1'b1;
    tick();
    dial   = 1'b0;
    status = S_RINGING;
    tick();
    tick();
    n_vec++;
    if (ringing !== 1'b1) begin
      n_err++;
      $display("FAIL ring_entry: got ringing=%b want 1", ringing);
    end
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      tick();
      n++;
      if (endCallCaller === 1'b1) seen = 1'b1;
    end
    n_vec++;
    if (!seen || n != int'(RING_TIMEOUT) + 1) begin
      n_err++;
      $display("FAIL ring_timeout_cycles: got %0d (seen=%0b) want %0d", n, seen,
               RING_TIMEOUT + 1);
    end
    n_vec++;
    if ({timed_out, ringing} !== 2'b10) begin
      n_err++;
      $display("FAIL ring_timed_out_flag: got to,ring=%b want 10", {timed_out, ringing});
    end
    status = S_IDLE;
    tick();
    tick();
    n_vec++;
    if ({endCallCaller, ringing, connected, timed_out} !== 4'b0001) begin
      n_err++;
      $display("FAIL ring_back_idle: got %b want 0001",
               {endCallCaller, ringing, connected, timed_out});
    end
  endtask

  task automatic test_rejection();
    dial = 1'b1;
    tick();
    dial = 1'b0;
    n_vec++;
    if ({startCall, timed_out} !== 2'b10) begin
      n_err++;
      $display("FAIL reject_dial_from_idle: got start,to=%b want 10", {startCall, timed_out});
    end
    status = S_RINGING;
    tick();
    tick();
    status = S_REJECTED;
    tick();
    n_vec++;
    if ({ringing, endCallCaller, connected} !== 3'b000) begin
      n_err++;
      $display("FAIL reject_to_idle: got ring,end,conn=%b want 000",
               {ringing, endCallCaller, connected});
    end
    tick();
    n_vec++;
    if ({endCallCaller, startCall} !== 2'b00) begin
      n_err++;
      $display("FAIL reject_no_pulse: got end,start=%b want 00", {endCallCaller, startCall});
    end
    status = S_IDLE;
  endtask

  task automatic test_overflow();
    logic [7:0] exp_c;
    int nsent;
    for (int i = 0; i < 9; i++) begin
      push_key(8'(8'h41 + i));
      if (i == 6) begin
        n_vec++;
        if (fifo_full !== 1'b0) begin
          n_err++;
          $display("FAIL ovf_not_full_at_7: got %b want 0", fifo_full);
        end
      end
      if (i == 7) begin
        n_vec++;
        if ({fifo_full, overflow} !== 2'b10) begin
          n_err++;
          $display("FAIL ovf_full_at_8: got full,ovf=%b want 10", {fifo_full, overflow});
        end
      end
    end
    n_vec++;
    if ({fifo_full, overflow} !== 2'b11) begin
      n_err++;
      $display("FAIL ovf_dropped_9th: got full,ovf=%b want 11", {fifo_full, overflow});
    end
    dial_to_connect();
    nsent = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (sendCharCaller === 1'b1) begin
        nsent++;
        n_vec++;
        exp_c = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
        if (charSent !== exp_c) begin
          n_err++;
          $display("FAIL ovf_char%0d: got %h want %h", nsent, charSent, exp_c);
        end
      end
    end
    n_vec++;
    if (nsent != 8 || sent_count !== 16'd8 || fifo_empty !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_send_total: got sends=%0d count=%0d empty=%b want 8,8,1", nsent,
               sent_count, fifo_empty);
    end
    status = S_IDLE;
    tick();
  endtask

  task automatic test_hangup_mid_stream();
    logic [7:0] exp_c;
    int nsent;
    int n;
    for (int i = 0; i < 5; i++) push_key(8'(8'h30 + i));
    dial_to_connect();
    nsent = 0;
    n = 0;
    while (nsent < 2 && n < 10) begin
      tick();
      n++;
      if (sendCharCaller === 1'b1) begin
        nsent++;
        n_vec++;
        exp_c = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
        if (charSent !== exp_c) begin
          n_err++;
          $display("FAIL hup_char%0d: got %h want %h", nsent, charSent, exp_c);
        end
      end
    end
    hangup = 1'b1;
    tick();
    hangup = 1'b0;
    n_vec++;
    if ({endCallCaller, sendCharCaller, sent_count} !== {2'b10, 16'd2}) begin
      n_err++;
      $display("FAIL hup_end_pulse: got end,send,count=%b,%b,%0d want 1,0,2", endCallCaller,
               sendCharCaller, sent_count);
    end
    n_vec++;
    if ({fifo_empty, fifo_full} !== 2'b00) begin
      n_err++;
      $display("FAIL hup_leftover: got empty,full=%b want 00", {fifo_empty, fifo_full});
    end
    status = S_IDLE;
    tick();
    tick();
  endtask

  task automatic test_async_reset();
    logic [7:0] exp_c;
    int nsent;
    dial_to_connect();
    nsent = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (sendCharCaller === 1'b1) begin
        nsent++;
        n_vec++;
        exp_c = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
        if (charSent !== exp_c) begin
          n_err++;
          $display("FAIL leftover_char%0d: got %h want %h", nsent, charSent, exp_c);
        end
      end
    end
    n_vec++;
    if (nsent != 3 || {connected, fifo_empty, sent_count} !== {2'b11, 16'd3}) begin
      n_err++;
      $display("FAIL leftover_total: got sends=%0d conn=%b empty=%b count=%0d want 3,1,1,3",
               nsent, connected, fifo_empty, sent_count);
    end
    push_key(8'h5A);
    #3;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    n_vec++;
    if (outs !== RESET_OUTS) begin
      n_err++;
      $display("FAIL async_reset_outputs: got %h want %h", outs, RESET_OUTS);
    end
    tick();
    #3;
    rst_n  = 1'b1;
    status = S_CALL;
    tick();
    n_vec++;
    if (outs !== RESET_OUTS) begin
      n_err++;
      $display("FAIL post_reset_idle: got %h want %h", outs, RESET_OUTS);
    end
    dial = 1'b1;
    tick();
    dial = 1'b0;
    n_vec++;
    if ({startCall, connected} !== 2'b10) begin
      n_err++;
      $display("FAIL post_reset_dial: got start,conn=%b want 10", {startCall, connected});
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_happy_path();
    test_ring_timeout();
    test_rejection();
    test_overflow();
    test_hangup_mid_stream();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", n_vec);
    $fatal(1);
  end

endmodule
